// File: rtl/seg_scan_capture_if.sv
// -----------------------------------------------------------------------------
// seg_scan_capture_if
//   Groups the multiplexed 7-segment display bus, the flag clear input and the
//   read-back results of seg_scan_capture.
//
//   Signals:
//     seg          7           segment lines, bit6=a ... bit0=g, active-high
//     dig_en       NUM_DIGITS  digit enables, active-high, expected one-hot
//     clear        1           synchronous clear of valid/bad flags
//     digits       4*NUM_DIGITS captured BCD, digit i at [4i+3:4i]
//     digit_valid  NUM_DIGITS  sticky: digit i holds a decoded value
//     bad_pattern  NUM_DIGITS  sticky: digit i showed an unrecognised pattern
//     update       1           one-cycle pulse on each capture
//     update_idx   3           index of the captured digit (valid with update)
//
//   Modports:
//     master  drives the display bus and clear, observes results
//     slave   the capture block
// -----------------------------------------------------------------------------
interface seg_scan_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   bad_pattern;
    logic                    update;
    logic [2:0]              update_idx;

    modport master (
        output seg, dig_en, clear,
        input  digits, digit_valid, bad_pattern, update, update_idx
    );

    modport slave (
        input  seg, dig_en, clear,
        output digits, digit_valid, bad_pattern, update, update_idx
    );
endinterface

// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
//   Watches a multiplexed 7-segment display bus and recovers the BCD value shown
//   on each digit. A {seg, dig_en} sample must stay identical for STABLE_CYCLES
//   consecutive edges before it is captured, which filters scan transitions.
//   Unrecognised segment patterns set a sticky per-digit bad flag instead.
//
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of seg_scan_capture_if (display bus + results)
//
//   Parameters:
//     NUM_DIGITS     number of multiplexed digits (1..8)
//     STABLE_CYCLES  identical samples required before capture (2..255)
// -----------------------------------------------------------------------------
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_capture_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int                    SAMPLE_W     = 7 + NUM_DIGITS;
    localparam logic [7:0]            STABLE_LIMIT = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] EN_ONE       = NUM_DIGITS'(1);

    // Returns {recognised, bcd}; anything outside the ten digit shapes,
    // including the blank pattern, is unrecognised.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1111110: decode_seg = {1'b1, 4'd0};
            7'b0110000: decode_seg = {1'b1, 4'd1};
            7'b1101101: decode_seg = {1'b1, 4'd2};
            7'b1111001: decode_seg = {1'b1, 4'd3};
            7'b0110011: decode_seg = {1'b1, 4'd4};
            7'b1011011: decode_seg = {1'b1, 4'd5};
            7'b1011111: decode_seg = {1'b1, 4'd6};
            7'b1110000: decode_seg = {1'b1, 4'd7};
            7'b1111111: decode_seg = {1'b1, 4'd8};
            7'b1111011: decode_seg = {1'b1, 4'd9};
            default:    decode_seg = {1'b0, 4'd0};
        endcase
    endfunction

    state_e                  state_q,  state_d;
    logic [7:0]              count_q,  count_d;
    logic [SAMPLE_W-1:0]     sample_q;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q,  valid_d;
    logic [NUM_DIGITS-1:0]   bad_q,    bad_d;
    logic                    update_q, update_d;
    logic [2:0]              idx_q,    idx_d;

    logic [SAMPLE_W-1:0] cur_sample;
    logic                same_sample;
    logic                en_onehot;
    logic [4:0]          decoded;
    logic [2:0]          en_idx;

    assign cur_sample  = {bus.seg, bus.dig_en};
    assign same_sample = (cur_sample == sample_q);
    assign en_onehot   = (bus.dig_en != '0) && ((bus.dig_en & (bus.dig_en - EN_ONE)) == '0);
    assign decoded     = decode_seg(bus.seg);

    // One-hot to binary; only consulted when dig_en is one-hot.
    always_comb begin
        en_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.dig_en[i]) en_idx = 3'(i);
        end
    end

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        logic capture;
        state_d  = state_q;
        count_d  = count_q;
        digits_d = digits_q;
        valid_d  = bus.clear ? '0 : valid_q;
        bad_d    = bus.clear ? '0 : bad_q;
        update_d = 1'b0;
        idx_d    = idx_q;
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_onehot) begin
                    state_d = SETTLE;
                    count_d = 8'd1;
                end else begin
                    count_d = 8'd0;
                end
            end
            SETTLE, HOLD: begin
                if (!same_sample) begin
                    // Any change restarts filtering on the new sample.
                    state_d = en_onehot ? SETTLE : IDLE;
                    count_d = en_onehot ? 8'd1 : 8'd0;
                end else if (state_q == SETTLE) begin
                    if (count_q + 8'd1 == STABLE_LIMIT) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                    count_d = count_q + 8'd1;
                end
                // HOLD with an unchanged sample: count stays saturated.
            end
            default: begin
                state_d = IDLE;
                count_d = 8'd0;
            end
        endcase

        // Capture is applied after clear so the captured digit's flag survives
        // a coincident clear.
        if (capture) begin
            update_d = 1'b1;
            idx_d    = en_idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.dig_en[i]) begin
                    if (decoded[4]) begin
                        digits_d[4*i +: 4] = decoded[3:0];
                        valid_d[i]         = 1'b1;
                    end else begin
                        bad_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= 8'd0;
            sample_q <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            bad_q    <= '0;
            update_q <= 1'b0;
            idx_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sample_q <= cur_sample;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            bad_q    <= bad_d;
            update_q <= update_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.bad_pattern = bad_q;
    assign bus.update      = update_q;
    assign bus.update_idx  = idx_q;

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Monitors a multiplexed 7-segment display bus: segment lines plus one-hot digit enables.
- Recovers the BCD value currently shown on each digit.
- Inverse of the BCD-to-segment decode path; used for display read-back and self-check in the clock design.
- Filters scan transitions with a stability counter and flags unrecognised segment patterns per digit.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 16, consecutive identical samples required before capture (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_en  input  NUM_DIGITS  digit enables, active-high, expected one-hot.
- clear  input  1  synchronous clear of valid/bad flags.
- digits  output  4*NUM_DIGITS  captured BCD; digit i at [4i+3:4i].
- digit_valid  output  NUM_DIGITS  sticky; digit i holds a decoded value.
- bad_pattern  output  NUM_DIGITS  sticky; digit i showed an unrecognised pattern.
- update  output  1  one-cycle pulse on each capture.
- update_idx  output  3  index of the digit captured; meaningful when update=1.

Behaviour:
- Reset (async assert, sync release): digits=0, digit_valid=0, bad_pattern=0, update=0, update_idx=0, internal sample register=0, stable count=0, FSM=IDLE.
- Each edge, {seg,dig_en} is compared with the internally held previous sample, then the held sample is replaced.
- Decode table (seg -> BCD):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - All other patterns are invalid.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: dig_en not one-hot (zero or multiple bits). Count=0. Go to SETTLE, count=1, on the first edge with one-hot dig_en.
  - SETTLE, same sample: count increments. On the edge where count reaches STABLE_CYCLES, capture, go to HOLD.
  - SETTLE or HOLD, sample differs: if the new dig_en is one-hot, go to SETTLE with count=1; otherwise go to IDLE.
  - HOLD, same sample: no further captures; count saturates.
- Capture, on the STABLE_CYCLES-th consecutive identical edge:
  - Valid pattern: digits[i] <= decoded value, digit_valid[i] <= 1, bad_pattern[i] unchanged.
  - Invalid pattern: digits[i] unchanged, bad_pattern[i] <= 1, digit_valid[i] unchanged.
  - Both cases: update=1 for exactly the following cycle, update_idx=i.
- Latency: first edge presenting a new stable input to outputs-updated = STABLE_CYCLES edges.
- clear: clears all digit_valid and bad_pattern bits on that edge; digits not cleared. If clear coincides with a capture, the captured digit's flag is set (capture wins); other digits are cleared.
- A glitch of one or more cycles restarts the count. Returning to the previous pattern re-captures and pulses update again.
- Blank pattern 0000000 is invalid.
- NUM_DIGITS>8 is unsupported. update_idx uses the low bits of the one-hot index.
- Reset mid-SETTLE discards the partial count; no update is produced.

Test Plan:
1. Reset release; hold seg=1111110, dig_en=0001 for 20 cycles -> update pulses once, 16 edges after first presentation; digits[3:0]=0, digit_valid=0001, update_idx=0.
2. Scan 4 digits 1,2,5,9 (patterns 0110000, 1101101, 1011011, 1111011; dig_en 0001, 0010, 0100, 1000), 32 cycles each -> digits=16'h9521, digit_valid=1111, four update pulses with idx 0,1,2,3.
3. dig_en=0100 with seg=1111111 for 10 cycles, one-cycle glitch to 1111110, then 1111111 for 16 cycles -> exactly one update, 16 cycles after the glitch; digits[11:8]=8.
4. seg=0000001, dig_en=0010 for 16 cycles -> bad_pattern=0010, digit_valid[1] unchanged, digits[7:4] unchanged, update pulse with idx 1. Then clear -> bad_pattern=0.
5. dig_en=0011 or 0000 held for 40 cycles with any seg -> no update, outputs unchanged.
6. Assert rst_n=0 at count 10 during SETTLE, release, reapply the same pattern -> capture occurs 16 edges after release, not earlier. clear asserted on the capture edge -> that digit's valid flag=1, others 0.
